// File: rtl/nodf_module_status_tracker.sv
// Activity and latency tracker for one non-dataflow HLS block (ap_ctrl_hs / ap_ctrl_chain).
// Counts starts, dones and ready cycles, measures latency and start-to-start interval, and freezes on finish.
module nodf_module_status_tracker #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic             active,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] ready_count,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] min_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic [LAT_W-1:0] last_interval,
    output logic             err_spurious_done,
    output logic             err_spurious_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic             done_ev;
    logic             start_ev;
    logic             txn_done;
    logic             tracking;
    logic [LAT_W-1:0] sample;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] int_cnt;
    logic             seen_start;

    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LAT_W-1:0] inc_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= IDLE;
            active    <= 1'b0;
        end else begin
            cur_state <= next_state;
            active    <= (next_state == RUN);
        end
    end

    // A done with ap_start in the same cycle is a back-to-back (RUN) or zero-latency (IDLE) transaction.
    always_comb begin
        next_state = cur_state;
        done_ev    = ap_done & ap_continue;
        start_ev   = 1'b0;
        txn_done   = 1'b0;
        tracking   = (cur_state != FINISHED);
        sample     = '0;
        case (cur_state)
            IDLE: begin
                start_ev = ap_start;
                txn_done = ap_start & done_ev;
                if (ap_start && !done_ev) next_state = RUN;
            end
            RUN: begin
                txn_done = done_ev;
                sample   = lat_cnt;
                if (done_ev) begin
                    start_ev = ap_start;
                    if (!ap_start) next_state = IDLE;
                end
            end
            default: ;
        endcase
        if (finish) next_state = FINISHED;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_count        <= '0;
            done_count         <= '0;
            ready_count        <= '0;
            last_latency       <= '0;
            min_latency        <= '1;
            max_latency        <= '0;
            last_interval      <= '0;
            err_spurious_done  <= 1'b0;
            err_spurious_ready <= 1'b0;
            lat_cnt            <= '0;
            int_cnt            <= '0;
            seen_start         <= 1'b0;
        end else if (tracking) begin
            if (ap_ready) ready_count <= inc_cnt(ready_count);
            if (txn_done) begin
                done_count   <= inc_cnt(done_count);
                last_latency <= sample;
                if (sample < min_latency) min_latency <= sample;
                if (sample > max_latency) max_latency <= sample;
            end
            if (start_ev) begin
                start_count <= inc_cnt(start_count);
                lat_cnt     <= {{(LAT_W-1){1'b0}}, 1'b1};
                int_cnt     <= '0;
                seen_start  <= 1'b1;
                if (seen_start) last_interval <= inc_lat(int_cnt);
            end else begin
                int_cnt <= inc_lat(int_cnt);
                if (cur_state == RUN) lat_cnt <= inc_lat(lat_cnt);
            end
            if (cur_state == IDLE && !ap_start) begin
                if (ap_done)  err_spurious_done  <= 1'b1;
                if (ap_ready) err_spurious_ready <= 1'b1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Self-checking bench for nodf_module_status_tracker: directed scenarios plus a randomized run
// compared against a timestamp-based reference model.
module tb_nodf_module_status_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b0;
    logic        finish = 1'b0;
    logic [1:0]  state;
    logic        active;
    logic [31:0] start_count, done_count, ready_count;
    logic [31:0] last_latency, min_latency, max_latency, last_interval;
    logic        err_spurious_done, err_spurious_ready;

    int checks = 0;
    int failures = 0;

    nodf_module_status_tracker #(.CNT_W(32), .LAT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .state(state), .active(active),
        .start_count(start_count), .done_count(done_count), .ready_count(ready_count),
        .last_latency(last_latency), .min_latency(min_latency), .max_latency(max_latency),
        .last_interval(last_interval),
        .err_spurious_done(err_spurious_done), .err_spurious_ready(err_spurious_ready)
    );

    always #5 clock = ~clock;

    // Reference model: latencies and intervals come from absolute cycle timestamps.
    longint      cyc = 0;
    longint      m_txn_start = 0;
    longint      m_prev_start = -1;
    logic [1:0]  m_state = 2'd0;
    logic [31:0] m_starts = 0, m_dones = 0, m_readys = 0;
    logic [31:0] m_last_lat = 0, m_min = 32'hFFFF_FFFF, m_max = 0, m_last_int = 0;
    logic        m_err_d = 1'b0, m_err_r = 1'b0;

    function automatic logic [31:0] cap(input longint v);
        return (v > 64'sd4294967295) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic note_start();
        m_starts = cap(longint'(m_starts) + 1);
        if (m_prev_start >= 0) m_last_int = cap(cyc - m_prev_start);
        m_prev_start = cyc;
        m_txn_start  = cyc;
    endtask

    task automatic note_done(input longint lat);
        logic [31:0] l;
        l = cap(lat);
        m_dones    = cap(longint'(m_dones) + 1);
        m_last_lat = l;
        if (l < m_min) m_min = l;
        if (l > m_max) m_max = l;
    endtask

    task automatic model_update();
        logic done;
        cyc++;
        done = ap_done && ap_continue;
        if (reset) begin
            m_state = 2'd0; m_starts = 0; m_dones = 0; m_readys = 0;
            m_last_lat = 0; m_min = 32'hFFFF_FFFF; m_max = 0; m_last_int = 0;
            m_err_d = 1'b0; m_err_r = 1'b0; m_prev_start = -1;
        end else if (m_state != 2'd2) begin
            if (ap_ready) m_readys = cap(longint'(m_readys) + 1);
            if (m_state == 2'd0) begin
                if (ap_start) begin
                    note_start();
                    if (done) note_done(0);
                    else m_state = 2'd1;
                end else begin
                    if (ap_done)  m_err_d = 1'b1;
                    if (ap_ready) m_err_r = 1'b1;
                end
            end else if (done) begin
                note_done(cyc - m_txn_start);
                if (ap_start) note_start();
                else m_state = 2'd0;
            end
            if (finish) m_state = 2'd2;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance through the rising edge.
    task automatic tick(input logic s, input logic r, input logic d, input logic c, input logic f);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 1, 0);
        reset = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset.state got=%0d exp=0", state); end
        checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL reset.active got=%0d exp=0", active); end
        checks++; if (start_count !== 32'd0) begin failures++; $display("[TB] FAIL reset.start_count got=%0d exp=0", start_count); end
        checks++; if (done_count !== 32'd0) begin failures++; $display("[TB] FAIL reset.done_count got=%0d exp=0", done_count); end
        checks++; if (min_latency !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL reset.min_latency got=%h exp=ffffffff", min_latency); end
        checks++; if (max_latency !== 32'd0) begin failures++; $display("[TB] FAIL reset.max_latency got=%0d exp=0", max_latency); end
        checks++; if ({err_spurious_done, err_spurious_ready} !== 2'b00) begin failures++; $display("[TB] FAIL reset.err_flags got=%b exp=00", {err_spurious_done, err_spurious_ready}); end
    endtask

    task automatic test_single_txn();
        do_reset(2);
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        checks++; if (state !== 2'd1 || active !== 1'b1) begin failures++; $display("[TB] FAIL single.run got=%0d/%0d exp=1/1", state, active); end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 1, 0);
        checks++; if (start_count !== 32'd1) begin failures++; $display("[TB] FAIL single.start_count got=%0d exp=1", start_count); end
        checks++; if (done_count !== 32'd1) begin failures++; $display("[TB] FAIL single.done_count got=%0d exp=1", done_count); end
        checks++; if (last_latency !== 32'd5) begin failures++; $display("[TB] FAIL single.last_latency got=%0d exp=5", last_latency); end
        checks++; if (min_latency !== 32'd5 || max_latency !== 32'd5) begin failures++; $display("[TB] FAIL single.minmax got=%0d/%0d exp=5/5", min_latency, max_latency); end
        checks++; if (ready_count !== 32'd1) begin failures++; $display("[TB] FAIL single.ready_count got=%0d exp=1", ready_count); end
        checks++; if (state !== 2'd0 || active !== 1'b0) begin failures++; $display("[TB] FAIL single.idle got=%0d/%0d exp=0/0", state, active); end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        tick(0, 0, 0, 1, 0);
        tick(1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL b2b.stay_run got=%0d exp=1", state); end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 1, 1, 0);
        checks++; if (start_count !== 32'd2 || done_count !== 32'd2) begin failures++; $display("[TB] FAIL b2b.counts got=%0d/%0d exp=2/2", start_count, done_count); end
        checks++; if (last_latency !== 32'd3) begin failures++; $display("[TB] FAIL b2b.last_latency got=%0d exp=3", last_latency); end
        checks++; if (min_latency !== 32'd3 || max_latency !== 32'd5) begin failures++; $display("[TB] FAIL b2b.minmax got=%0d/%0d exp=3/5", min_latency, max_latency); end
        checks++; if (last_interval !== 32'd5) begin failures++; $display("[TB] FAIL b2b.last_interval got=%0d exp=5", last_interval); end
        checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL b2b.idle got=%0d exp=0", state); end
    endtask

    task automatic test_chain_stall();
        do_reset(2);
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0);
        checks++; if (done_count !== 32'd0 || state !== 2'd1) begin failures++; $display("[TB] FAIL stall.pending got=%0d/%0d exp=0/1", done_count, state); end
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 1, 0);
        checks++; if (done_count !== 32'd1) begin failures++; $display("[TB] FAIL stall.done_count got=%0d exp=1", done_count); end
        checks++; if (last_latency !== 32'd7) begin failures++; $display("[TB] FAIL stall.last_latency got=%0d exp=7", last_latency); end
    endtask

    task automatic test_zero_latency();
        do_reset(2);
        tick(1, 1, 1, 1, 0);
        checks++; if (start_count !== 32'd1 || done_count !== 32'd1) begin failures++; $display("[TB] FAIL zero.counts got=%0d/%0d exp=1/1", start_count, done_count); end
        checks++; if (last_latency !== 32'd0 || min_latency !== 32'd0) begin failures++; $display("[TB] FAIL zero.latency got=%0d/%0d exp=0/0", last_latency, min_latency); end
        checks++; if (state !== 2'd0 || err_spurious_done !== 1'b0) begin failures++; $display("[TB] FAIL zero.state_err got=%0d/%0d exp=0/0", state, err_spurious_done); end
    endtask

    task automatic test_spurious();
        do_reset(2);
        tick(0, 1, 1, 1, 0);
        checks++; if (err_spurious_done !== 1'b1 || err_spurious_ready !== 1'b1) begin failures++; $display("[TB] FAIL spur.flags got=%b%b exp=11", err_spurious_done, err_spurious_ready); end
        checks++; if (done_count !== 32'd0 || ready_count !== 32'd1) begin failures++; $display("[TB] FAIL spur.counts got=%0d/%0d exp=0/1", done_count, ready_count); end
        tick(1, 0, 0, 1, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 1, 0);
        checks++; if (err_spurious_done !== 1'b1 || err_spurious_ready !== 1'b1) begin failures++; $display("[TB] FAIL spur.sticky got=%b%b exp=11", err_spurious_done, err_spurious_ready); end
        do_reset(1);
        checks++; if (err_spurious_done !== 1'b0 || err_spurious_ready !== 1'b0) begin failures++; $display("[TB] FAIL spur.cleared got=%b%b exp=00", err_spurious_done, err_spurious_ready); end
    endtask

    task automatic test_finish();
        do_reset(2);
        tick(1, 1, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);
        checks++; if (state !== 2'd2 || active !== 1'b0) begin failures++; $display("[TB] FAIL fin.state got=%0d/%0d exp=2/0", state, active); end
        tick(0, 1, 1, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++; if (done_count !== 32'd0 || start_count !== 32'd1) begin failures++; $display("[TB] FAIL fin.frozen got=%0d/%0d exp=0/1", done_count, start_count); end
        checks++; if (ready_count !== 32'd1 || err_spurious_done !== 1'b0) begin failures++; $display("[TB] FAIL fin.ready_err got=%0d/%0d exp=1/0", ready_count, err_spurious_done); end
        do_reset(1);
        checks++; if (state !== 2'd0 || start_count !== 32'd0) begin failures++; $display("[TB] FAIL fin.reset got=%0d/%0d exp=0/0", state, start_count); end
        // Done in the same cycle as finish is still recorded.
        tick(1, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 1, 1, 1);
        checks++; if (done_count !== 32'd1 || last_latency !== 32'd2 || state !== 2'd2) begin failures++; $display("[TB] FAIL fin.same_cycle got=%0d/%0d/%0d exp=1/2/2", done_count, last_latency, state); end
    endtask

    task automatic test_random();
        logic s, r, d, c, f;
        reset = 1'b1;
        tick(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 399) == 0);
            reset = ($urandom_range(0, 149) == 0);
            tick(s, r, d, c, f);
            checks++; if (state !== m_state || active !== (m_state == 2'd1)) begin failures++; $display("[TB] FAIL rand.state cyc=%0d got=%0d/%0d exp=%0d", cyc, state, active, m_state); end
            checks++; if (start_count !== m_starts || done_count !== m_dones || ready_count !== m_readys) begin failures++; $display("[TB] FAIL rand.counts cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, start_count, done_count, ready_count, m_starts, m_dones, m_readys); end
            checks++; if (last_latency !== m_last_lat || min_latency !== m_min || max_latency !== m_max) begin failures++; $display("[TB] FAIL rand.latency cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, last_latency, min_latency, max_latency, m_last_lat, m_min, m_max); end
            checks++; if (last_interval !== m_last_int) begin failures++; $display("[TB] FAIL rand.interval cyc=%0d got=%0d exp=%0d", cyc, last_interval, m_last_int); end
            checks++; if (err_spurious_done !== m_err_d || err_spurious_ready !== m_err_r) begin failures++; $display("[TB] FAIL rand.errs cyc=%0d got=%b%b exp=%b%b", cyc, err_spurious_done, err_spurious_ready, m_err_d, m_err_r); end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single_txn();
        test_back_to_back();
        test_chain_stall();
        test_zero_latency();
        test_spurious();
        test_finish();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nodf_module_status_tracker.md
Name: nodf_module_status_tracker

Overview:
Synthesizable status tracker for one non-dataflow HLS block using ap_ctrl_hs/ap_ctrl_chain handshakes. It samples ap_start/ap_ready/ap_done/ap_continue and classifies module activity. It counts transactions, measures per-transaction latency and start-to-start interval, and flags protocol anomalies. It sits beside the monitored block in the simulation/debug wrapper and freezes all results when the run signals finish.

Parameters:
CNT_W, 32, width of transaction/ready counters
LAT_W, 32, width of latency and interval measurements

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ap_start  in  1  monitored block start request
ap_ready  in  1  monitored block input-accepted pulse
ap_done  in  1  monitored block completion
ap_continue  in  1  downstream accept of done; tie 1 for ap_ctrl_hs
finish  in  1  end-of-run indication from testbench
state  out  2  0=IDLE, 1=RUN, 2=FINISHED
active  out  1  high while state==RUN
start_count  out  CNT_W  accepted transaction starts
done_count  out  CNT_W  completed transactions
ready_count  out  CNT_W  cycles with ap_ready=1 (not FINISHED)
last_latency  out  LAT_W  latency of most recent completed transaction
min_latency  out  LAT_W  smallest latency so far
max_latency  out  LAT_W  largest latency so far
last_interval  out  LAT_W  cycles between the two most recent start events
err_spurious_done  out  1  sticky: ap_done seen while IDLE with no start
err_spurious_ready  out  1  sticky: ap_ready seen while IDLE with ap_start=0

Behaviour:
- All outputs registered. An event sampled at edge N is visible after edge N.
- Reset (sync, active-high) has priority over everything:
  - state=IDLE; all counts, last_latency, max_latency and last_interval = 0.
  - min_latency = all ones; error flags = 0.
  - Internal latency counter and interval counter = 0; first-start flag cleared.
- Definitions:
  - start event = state IDLE and ap_start=1, or state RUN with done event and ap_start=1 (back-to-back).
  - done event = ap_done=1 and ap_continue=1.
- Interval counter:
  - Increments every cycle not FINISHED, saturating.
  - On each start event after the first, last_interval <= counter+1, then counter cleared.
  - On the first start event only, counter is cleared.
- IDLE:
  - ap_start=1, no done: start_count++, latency counter <= 1, go RUN.
  - ap_start=1 with done event in the same cycle: zero-latency transaction. start_count++, done_count++, latency sample 0, stay IDLE.
  - ap_done=1 with ap_start=0: set err_spurious_done, no counting.
  - ap_ready=1 with ap_start=0: set err_spurious_ready.
- RUN:
  - Latency counter increments each cycle, saturating at all ones.
  - Done event: sample = latency counter. done_count++; last_latency <= sample; min/max updated by unsigned compare.
  - If ap_start=1 in the same cycle: start_count++, latency counter <= 1, stay RUN. Otherwise go IDLE.
  - ap_done with ap_continue=0: no event, keep counting (ap_ctrl_chain stall).
- ready_count increments on every ap_ready=1 cycle in IDLE or RUN.
- finish:
  - finish=1 sampled (reset=0) moves any state to FINISHED.
  - FINISHED is sticky until reset; all counters and measurements freeze.
  - An event in the same cycle as finish is still recorded.
  - A transaction in flight is not counted as done.
- Saturation: every counter holds at all ones; no wrap-around.
- Reset asserted mid-transaction discards the transaction and returns to IDLE with reset values.

Test Plan:
- Reset: hold reset 3 cycles -> state=0, start_count=0, min_latency=0xFFFFFFFF, error flags 0.
- Single txn: ap_start high at cycle 2, ap_done+ap_continue pulse at cycle 7 -> start_count=1, done_count=1, last_latency=5, min=max=5, state back to 0.
- Back-to-back: done at cycle 7 with ap_start still 1, next done at cycle 10 -> start_count=2, done_count=2, last_latency=3, min=3, max=5, last_interval=5.
- Chain stall: ap_done=1, ap_continue=0 for 4 cycles then ap_continue=1 -> latency includes the 4 stall cycles; done_count increments once.
- Spurious: ap_done=1 and ap_ready=1 while IDLE, ap_start=0 -> both error flags set, done_count unchanged; flags persist until reset.
- Finish mid-run: start txn, assert finish before done -> state=2, done_count unchanged, later ap_done ignored; reset returns to IDLE.
